// File: rtl/bcd_step_counter.sv
// Multi-digit packed-BCD up/down counter stepped by edge-detected front-panel switches.
// Switch i adds or subtracts 10^i; queued edges are serviced one per clock, lowest index first.
module bcd_step_counter #(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned NSW      = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSW-1:0]      sw,
  input  logic                dir,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] dec_out,
  output logic                ovf,
  output logic                unf,
  output logic                busy
);

  localparam int unsigned W = 4 * DIGITS;

  logic [NSW-1:0] s1_q, s2_q, s3_q;
  logic [NSW-1:0] pending_q, pending_d;
  logic [NSW-1:0] valid_mask, rise, serviced;
  logic [W-1:0]   count_q, count_d, stepped, clamped;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           found, wrapped;
  int unsigned    k;

  // Switches beyond the last digit have no weight and never become pending.
  always_comb begin
    valid_mask = '0;
    for (int unsigned i = 0; i < NSW; i++) begin
      valid_mask[i] = (i < DIGITS);
    end
  end

  assign rise = s2_q & ~s3_q & valid_mask;

  always_comb begin
    serviced = '0;
    found    = 1'b0;
    k        = 0;
    for (int unsigned i = 0; i < NSW; i++) begin
      if (pending_q[i] && !found) begin
        found       = 1'b1;
        serviced[i] = 1'b1;
        k           = i;
      end
    end
  end

  // Ripple a +/-1 from digit k upward; carry out of the top digit flags wrap.
  always_comb begin
    logic [3:0] digit;
    logic       carry;
    stepped = count_q;
    carry   = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      digit = count_q[4*j +: 4];
      if (j >= k && carry) begin
        if (!dir) begin
          if (digit == 4'd9) begin
            digit = 4'd0;
          end else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            digit = 4'd9;
          end else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      stepped[4*j +: 4] = digit;
    end
    wrapped = carry;
  end

  always_comb begin
    for (int unsigned j = 0; j < DIGITS; j++) begin
      clamped[4*j +: 4] = (load_val[4*j +: 4] > 4'd9) ? 4'd9 : load_val[4*j +: 4];
    end
  end

  always_comb begin
    count_d   = count_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    pending_d = (pending_q & ~serviced) | rise;
    if (load) begin
      count_d   = clamped;
      pending_d = '0;
    end else if (found) begin
      count_d = stepped;
      if (wrapped) begin
        if (dir) begin
          unf_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        if (SATURATE) begin
          count_d = dir ? '0 : {DIGITS{4'h9}};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      s1_q      <= sw;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign dec_out = count_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign busy    = |pending_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Bench for bcd_step_counter: wrap and saturate instances share stimulus and are checked
// every cycle against an integer-arithmetic model, plus directed literal expectations.
module tb_bcd_step_counter;

  localparam int D = 3;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           dir = 1'b0;
  logic           load = 1'b0;
  logic [N-1:0]   sw = '0;
  logic [4*D-1:0] load_val = '0;
  logic [4*D-1:0] dec_w, dec_s;
  logic           ovf_w, unf_w, busy_w, ovf_s, unf_s, busy_s;

  int checks = 0;
  int failures = 0;
  int ovf_cnt_w = 0, unf_cnt_w = 0, ovf_cnt_s = 0, unf_cnt_s = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_step_counter #(.DIGITS(D), .NSW(N), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .sw(sw), .dir(dir), .load(load), .load_val(load_val),
    .dec_out(dec_w), .ovf(ovf_w), .unf(unf_w), .busy(busy_w)
  );

  bcd_step_counter #(.DIGITS(D), .NSW(N), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .sw(sw), .dir(dir), .load(load), .load_val(load_val),
    .dec_out(dec_s), .ovf(ovf_s), .unf(unf_s), .busy(busy_s)
  );

  function automatic int pow10(int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(int v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(logic [4*D-1:0] b);
    int r = 0;
    int d;
    for (int i = D - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: values kept as plain integers, switch history as sampled words.
  int           m_vw = 0, m_vs = 0;
  logic [N-1:0] m_pend = '0, h1 = '0, h2 = '0, h3 = '0;
  bit           m_ovf_w = 0, m_unf_w = 0, m_ovf_s = 0, m_unf_s = 0;

  always @(posedge clk) begin
    logic [N-1:0] r;
    int kk, p, md, t;
    m_ovf_w = 0; m_unf_w = 0; m_ovf_s = 0; m_unf_s = 0;
    if (rst) begin
      m_vw = 0; m_vs = 0; m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
    end else begin
      r = h2 & ~h3;
      for (int i = D; i < N; i++) r[i] = 1'b0;
      if (load) begin
        m_vw = clamp_val(load_val);
        m_vs = m_vw;
        m_pend = '0;
      end else begin
        if (m_pend != 0) begin
          kk = 0;
          while (!m_pend[kk]) kk++;
          m_pend[kk] = 1'b0;
          p = pow10(kk);
          md = pow10(D);
          if (!dir) begin
            t = m_vw + p;
            if (t >= md) begin m_ovf_w = 1; t = t - md; end
            m_vw = t;
            t = m_vs + p;
            if (t >= md) begin m_ovf_s = 1; t = md - 1; end
            m_vs = t;
          end else begin
            t = m_vw - p;
            if (t < 0) begin m_unf_w = 1; t = t + md; end
            m_vw = t;
            t = m_vs - p;
            if (t < 0) begin m_unf_s = 1; t = 0; end
            m_vs = t;
          end
        end
        m_pend = m_pend | r;
      end
      h3 = h2; h2 = h1; h1 = sw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dec_w", int'(dec_w), int'(to_bcd(m_vw)));
      check("ovf_w", int'(ovf_w), int'(m_ovf_w));
      check("unf_w", int'(unf_w), int'(m_unf_w));
      check("busy_w", int'(busy_w), int'(m_pend != 0));
      check("dec_s", int'(dec_s), int'(to_bcd(m_vs)));
      check("ovf_s", int'(ovf_s), int'(m_ovf_s));
      check("unf_s", int'(unf_s), int'(m_unf_s));
      check("busy_s", int'(busy_s), int'(m_pend != 0));
      if (ovf_w) ovf_cnt_w++;
      if (unf_w) unf_cnt_w++;
      if (ovf_s) ovf_cnt_s++;
      if (unf_s) unf_cnt_s++;
    end
  end

  task automatic press(int idx, logic d);
    dir = d;
    sw[idx] = 1'b1;
    @(negedge clk);
    sw[idx] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_load(logic [4*D-1:0] v);
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c0, c1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_dec", int'(dec_w), 'h000);
    check("reset_ovf", int'(ovf_w), 0);
    check("reset_unf", int'(unf_w), 0);
    check("reset_busy", int'(busy_w), 0);
    rst = 1'b0;
    @(negedge clk);

    press(0, 1'b0); check("step_001", int'(dec_w), 'h001);
    press(1, 1'b0); check("step_011", int'(dec_w), 'h011);
    press(2, 1'b0); check("step_111", int'(dec_w), 'h111);

    rst = 1'b1; @(negedge clk); rst = 1'b0;
    sw = 4'b0111;
    @(negedge clk);
    sw = '0;
    repeat (3) @(negedge clk);
    check("simul_001", int'(dec_w), 'h001);
    @(negedge clk); check("simul_011", int'(dec_w), 'h011);
    @(negedge clk); check("simul_111", int'(dec_w), 'h111);
    check("simul_busy", int'(busy_w), 0);
    press(3, 1'b0); check("sw3_ignored", int'(dec_w), 'h111);

    do_load(12'h999);
    c0 = ovf_cnt_w;
    press(0, 1'b0); check("wrap_up", int'(dec_w), 'h000);
    check("wrap_ovf_pulses", ovf_cnt_w - c0, 1);
    do_load(12'h000);
    c0 = unf_cnt_w;
    press(1, 1'b1); check("wrap_down", int'(dec_w), 'h990);
    check("wrap_unf_pulses", unf_cnt_w - c0, 1);
    do_load(12'h199);
    press(0, 1'b0); check("carry_200", int'(dec_w), 'h200);
    do_load(12'hA3F); check("load_clamp", int'(dec_w), 'h939);

    do_load(12'h995);
    c0 = ovf_cnt_s;
    press(1, 1'b0); check("sat_999", int'(dec_s), 'h999);
    press(0, 1'b0); check("sat_hold", int'(dec_s), 'h999);
    check("sat_ovf_pulses", ovf_cnt_s - c0, 2);
    do_load(12'h005);
    c1 = unf_cnt_s;
    press(1, 1'b1); check("sat_000", int'(dec_s), 'h000);
    check("sat_unf_pulses", unf_cnt_s - c1, 1);

    dir = 1'b0;
    sw[0] = 1'b1; @(negedge clk); sw[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("pend_busy", int'(busy_w), 1);
    load = 1'b1; load_val = 12'h123;
    @(negedge clk);
    load = 1'b0;
    check("load_wins", int'(dec_w), 'h123);
    check("load_clears", int'(busy_w), 0);
    repeat (4) @(negedge clk);
    check("load_no_step", int'(dec_w), 'h123);

    sw[1] = 1'b1; @(negedge clk); sw[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("midreset_dec", int'(dec_w), 'h000);
    check("midreset_busy", int'(busy_w), 0);
    repeat (4) @(negedge clk);
    check("midreset_hold", int'(dec_w), 'h000);

    sw[0] = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("held_once", int'(dec_w), 'h001);
    repeat (4) @(negedge clk);
    check("held_stays", int'(dec_w), 'h001);
    sw = '0;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 39) == 0);
      load_val = 12'($urandom);
      dir = 1'($urandom);
      if ($urandom_range(0, 2) == 0) sw = sw ^ 4'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; load = 1'b0; sw = '0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
